// File: rtl/uart_pkg.sv
// Shared UART definitions used by the 8N1 receiver and its downstream byte FIFO.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-side first-word-fall-through byte FIFO placed behind the UART receiver.
// Reports fill level, an almost-full warning and a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int  DATA_BITS   = UART_DATA_BITS,
  parameter int  DEPTH       = 16,
  parameter int  ALMOST_FULL = 12,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  input  logic                 out_ready,
  output logic [AW:0]          count,
  output logic                 almost_full,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(ALMOST_FULL);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 push, pop;

  // Status comes only from registered count, so in_valid/out_ready never loop back.
  assign in_ready    = (count_q != DEPTH_C);
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= AF_C);
  assign overrun     = overrun_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW)'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A set coinciding with a software clear must not be lost.
    if (in_valid && !in_ready) overrun_d = 1'b1;
    else if (overrun_clr)      overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the 8N1 UART receiver.
- Accepts received bytes over a valid/ready handshake and stores them in a circular FIFO.
- Presents bytes first-word-fall-through to the consumer (CPU bus or protocol parser).
- Reports fill level, an almost-full warning and a sticky overrun flag, so software can see that the receiver was stalled and line data was lost.

Parameters:
- DATA_BITS, 8, width of one received character; matches the receiver's data port.
- DEPTH, 16, number of storage entries; must be a power of two, >= 2.
- ALMOST_FULL, 12, level at or above which almost_full asserts; must satisfy 1 <= ALMOST_FULL <= DEPTH.
- AW (localparam), $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  receiver has a byte on in_data
- in_data  in  DATA_BITS  received byte
- in_ready  out  1  FIFO accepts a byte this cycle
- out_valid  out  1  out_data holds the oldest stored byte
- out_data  out  DATA_BITS  oldest stored byte
- out_ready  in  1  consumer takes out_data this cycle
- count  out  AW+1  current number of stored bytes, 0..DEPTH
- almost_full  out  1  count >= ALMOST_FULL
- overrun  out  1  sticky: a byte was offered while the FIFO was full
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, overrun=0.
  - Outputs after reset: out_valid=0, in_ready=1, almost_full=0.
  - Storage contents are not reset; out_data is don't-care while out_valid=0.
- Push: in_valid && in_ready at a clk rising edge.
  - Writes mem[wr_ptr] = in_data.
  - wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Pop: out_valid && out_ready at a clk rising edge; rd_ptr increments modulo DEPTH.
- Combinational outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], read asynchronously from the register array.
- Latency: a byte pushed at edge N is visible with out_valid=1 after edge N; consumer can pop at edge N+1. No same-cycle bypass from in_data to out_data.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop.
  - Never exceeds DEPTH and never underflows.
- Full (count==DEPTH):
  - in_ready=0, so no push is possible even if a pop occurs the same cycle.
  - in_ready returns to 1 the cycle after a pop.
- Empty (count==0):
  - out_valid=0 and out_ready is ignored.
  - A push in this cycle does not produce output until the next cycle.
- Push and pop in the same cycle, count between 1 and DEPTH-1: both occur, and pointers advance independently.
- Overrun:
  - Set on any rising edge where in_valid=1 and in_ready=0.
  - Cleared on an edge where overrun_clr=1.
  - If set and clear coincide, set wins and overrun stays 1.
  - The offered byte is not stored; the upstream receiver keeps holding it per the handshake.
- almost_full: combinational compare of count against ALMOST_FULL.
- Reset mid-operation: all stored data is discarded, and state returns immediately to the reset values above.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_BITS = 8.
  - Typedef uart_byte_t (logic [UART_DATA_BITS-1:0]).
  - The receiver and this FIFO both use these.
- No sub-module: storage array, two pointers, count and overrun flag are implemented inline in one module.

Test Plan:
- Reset, then push 0x41,0x42,0x43 on consecutive cycles with out_ready=0 -> count=3, out_data=0x41. Then hold out_ready=1 -> pops 0x41,0x42,0x43 in order, and out_valid=0 after the third pop.
- Push 16 bytes 0x00..0x0F with DEPTH=16 -> in_ready=0 and count=16 after the 16th edge, almost_full=1 from count=12. Then pop all -> data 0x00..0x0F in order, pointers wrapped to 0.
- Full FIFO, hold in_valid=1 with in_data=0xAA for 2 cycles -> overrun=1, count stays 16, 0xAA is never output. Pulse overrun_clr with in_valid=0 -> overrun=0.
- Count=5, assert push (0x55) and pop together for 10 cycles -> count stays 5, and output order is preserved across the pointer wrap.
- Full FIFO, in_valid=1 and overrun_clr=1 on the same edge -> overrun=1 (set wins).
- Count=7, assert rst mid-stream between edges -> count=0, out_valid=0, in_ready=1, overrun=0 immediately, without waiting for a clock edge.
